// File: rtl/fir_seq_pkg.sv
// Shared encodings for the FIR control sequencer: FSM states and command opcodes.
package fir_seq_pkg;

   localparam logic [2:0] ST_SETUP  = 3'd0;
   localparam logic [2:0] ST_IDLE   = 3'd1;
   localparam logic [2:0] ST_LOAD   = 3'd2;
   localparam logic [2:0] ST_GAP    = 3'd3;
   localparam logic [2:0] ST_STREAM = 3'd4;

   localparam logic [1:0] OP_STOP   = 2'b00;
   localparam logic [1:0] OP_WCOEF  = 2'b01;
   localparam logic [1:0] OP_COMMIT = 2'b10;
   localparam logic [1:0] OP_SAMPLE = 2'b11;

   // Counter/pointer width that stays at least one bit for degenerate sizes.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fir_seq_lat_pipe.sv
// Valid shift register matching the FIR latency; flush drops every result still in flight.
module fir_seq_lat_pipe #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic flush_i,
   input  logic valid_i,
   output logic valid_o
);

   logic [DEPTH-1:0] pipe_q, pipe_d;

   always_comb begin
      pipe_d    = '0;
      pipe_d[0] = valid_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      if (flush_i) begin
         pipe_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fir_seq_ctrl.sv
// Command sequencer driving the FIR control pins: coefficient load and sample streaming.
// Build option FIR_SEQ_SAT_EN narrows y_data to X_N_SIZE with signed saturation.
module fir_seq_ctrl
   import fir_seq_pkg::*;
#(
   parameter int unsigned X_N_SIZE     = 8,
   parameter int unsigned TAP_SIZE     = 6,
   parameter int unsigned NBR_OF_TAPS  = 3,
   parameter int unsigned Y_N_SIZE     = 14,
   parameter int unsigned SETUP_CYCLES = 4,
   parameter int unsigned FIR_LATENCY  = 2,
`ifdef FIR_SEQ_SAT_EN
   localparam int unsigned YD_W = X_N_SIZE
`else
   localparam int unsigned YD_W = Y_N_SIZE
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [X_N_SIZE-1:0] cmd_data,
   output logic [X_N_SIZE-1:0] fir_x_n,
   output logic                fir_tvalid,
   output logic                fir_set_coeffs,
   input  logic [Y_N_SIZE-1:0] fir_y_n,
   output logic                y_valid,
   output logic [YD_W-1:0]     y_data,
   output logic                busy
);

   localparam int unsigned PTR_W = clog2_min1(NBR_OF_TAPS);
   localparam int unsigned CNT_W = clog2_min1(SETUP_CYCLES);

   logic [2:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PTR_W-1:0]    wptr_q, wptr_d;
   logic [PTR_W-1:0]    ld_ptr_q, ld_ptr_d;
   logic [TAP_SIZE-1:0] shadow_q [NBR_OF_TAPS];
   logic [TAP_SIZE-1:0] shadow_d [NBR_OF_TAPS];

   logic                cmd_ready_q, cmd_ready_d;
   logic                busy_q, busy_d;
   logic [X_N_SIZE-1:0] x_n_q, x_n_d;
   logic                tvalid_q, tvalid_d;
   logic                set_q, set_d;
   logic                y_valid_q, y_valid_d;
   logic [YD_W-1:0]     y_data_q, y_data_d;

   logic                accept, acc_sample, flush, pipe_out;
   logic [TAP_SIZE-1:0] ld_coef;
   logic [YD_W-1:0]     y_next;

   assign accept     = cmd_valid & cmd_ready_q;
   assign acc_sample = accept && (cmd_op == OP_SAMPLE);
   // Leaving STREAM discards every result whose FIR input has already been presented.
   assign flush      = (state_q == ST_STREAM) && (state_d != ST_STREAM);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wptr_d   = wptr_q;
      ld_ptr_d = ld_ptr_q;
      shadow_d = shadow_q;
      if (accept && (cmd_op == OP_WCOEF)) begin
         shadow_d[wptr_q] = cmd_data[TAP_SIZE-1:0];
         wptr_d = (wptr_q == PTR_W'(NBR_OF_TAPS - 1)) ? '0 : wptr_q + 1'b1;
      end
      case (state_q)
         ST_SETUP: begin
            if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (accept && (cmd_op == OP_COMMIT)) begin
               state_d  = ST_LOAD;
               ld_ptr_d = PTR_W'(NBR_OF_TAPS - 1);
            end else if (acc_sample) begin
               state_d = ST_STREAM;
            end
         end
         ST_LOAD: begin
            if (ld_ptr_q == '0) begin
               state_d = ST_GAP;
            end else begin
               ld_ptr_d = ld_ptr_q - 1'b1;
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
            wptr_d  = '0;
         end
         ST_STREAM: begin
            if (accept && (cmd_op == OP_STOP)) begin
               state_d = ST_IDLE;
            end else if (accept && (cmd_op == OP_COMMIT)) begin
               state_d  = ST_LOAD;
               ld_ptr_d = PTR_W'(NBR_OF_TAPS - 1);
            end
         end
         default: state_d = ST_SETUP;
      endcase
   end

`ifdef FIR_SEQ_SAT_EN
   localparam logic signed [Y_N_SIZE-1:0] Y_MAX = Y_N_SIZE'((2 ** (X_N_SIZE - 1)) - 1);
   localparam logic signed [Y_N_SIZE-1:0] Y_MIN = ~Y_MAX;

   always_comb begin
      if ($signed(fir_y_n) > Y_MAX) begin
         y_next = Y_MAX[X_N_SIZE-1:0];
      end else if ($signed(fir_y_n) < Y_MIN) begin
         y_next = Y_MIN[X_N_SIZE-1:0];
      end else begin
         y_next = fir_y_n[X_N_SIZE-1:0];
      end
   end
`else
   assign y_next = fir_y_n;
`endif

   // Outputs are derived from the next state so every pin comes straight from a flop.
   always_comb begin
      ld_coef     = shadow_q[ld_ptr_d];
      cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_STREAM);
      busy_d      = ~cmd_ready_d;
      tvalid_d    = (state_d == ST_STREAM);
      set_d       = (state_d == ST_LOAD);
      x_n_d       = '0;
      if (state_d == ST_LOAD) begin
         x_n_d = {{(X_N_SIZE - TAP_SIZE){ld_coef[TAP_SIZE-1]}}, ld_coef};
      end else if (acc_sample) begin
         x_n_d = cmd_data;
      end
      // fir_y_n is captured on the edge that raises y_valid.
      y_valid_d = pipe_out & ~flush;
      y_data_d  = y_valid_d ? y_next : y_data_q;
   end

   fir_seq_lat_pipe #(
      .DEPTH (FIR_LATENCY)
   ) u_lat_pipe (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush),
      .valid_i (acc_sample),
      .valid_o (pipe_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_SETUP;
         cnt_q       <= '0;
         wptr_q      <= '0;
         ld_ptr_q    <= '0;
         shadow_q    <= '{default: '0};
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b1;
         x_n_q       <= '0;
         tvalid_q    <= 1'b0;
         set_q       <= 1'b0;
         y_valid_q   <= 1'b0;
         y_data_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wptr_q      <= wptr_d;
         ld_ptr_q    <= ld_ptr_d;
         shadow_q    <= shadow_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         x_n_q       <= x_n_d;
         tvalid_q    <= tvalid_d;
         set_q       <= set_d;
         y_valid_q   <= y_valid_d;
         y_data_q    <= y_data_d;
      end
   end

   assign cmd_ready      = cmd_ready_q;
   assign busy           = busy_q;
   assign fir_x_n        = x_n_q;
   assign fir_tvalid     = tvalid_q;
   assign fir_set_coeffs = set_q;
   assign y_valid        = y_valid_q;
   assign y_data         = y_data_q;

endmodule
